vga_plot_arbiter: RTL and testbench

- Shares the single vga_adapter write port (x, y, colour, plot) between several drawing engines: board, player sprite and coin eraser.
- Each requester asks for a solid-colour rectangle fill.
- The arbiter grants one requester at a time, round-robin, and sequences the rectangle's pixels one per clock onto the plot port.
- It sits between the game datapath ("main") and the VGA adapter in the 160x120, 9-bit-colour build.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/rr_picker.sv | 35 +++
 rtl/vga_plot_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_pkg : shared screen geometry, pixel field widths, FSM states |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_picker : combinational round-robin winner select              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_winner,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Search upward from the slot after the previous winner, wrapping.
    always_comb begin
        int j;
        j        = 0;
        o_winner = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(i_last) + k) % NUM_REQ;
            if (!o_valid && i_req[IDX_W'(j)]) begin
                o_valid              = 1'b1;
                o_winner[IDX_W'(j)]  = 1'b1;
                o_idx                = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_plot_arbiter : round-robin rectangle-fill sequencer sharing  |
// |                    the VGA adapter plot port                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vga_plot_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [vga_pkg::X_W*NUM_REQ-1:0]        rect_x,
    input  logic [vga_pkg::Y_W*NUM_REQ-1:0]        rect_y,
    input  logic [vga_pkg::X_W*NUM_REQ-1:0]        rect_w,
    input  logic [vga_pkg::Y_W*NUM_REQ-1:0]        rect_h,
    input  logic [vga_pkg::COLOUR_W*NUM_REQ-1:0]   rect_colour,
    output logic [NUM_REQ-1:0]                     grant,
    output logic [NUM_REQ-1:0]                     done,
    output logic                                   busy,
    output logic [vga_pkg::X_W-1:0]                oX,
    output logic [vga_pkg::Y_W-1:0]                oY,
    output logic [vga_pkg::COLOUR_W-1:0]           oColour,
    output logic                                   oPlot
);

    import vga_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [X_W-1:0]      w_x   [NUM_REQ];
    logic [Y_W-1:0]      w_y   [NUM_REQ];
    logic [X_W-1:0]      w_w   [NUM_REQ];
    logic [Y_W-1:0]      w_h   [NUM_REQ];
    logic [COLOUR_W-1:0] w_col [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_x[gi]   = rect_x[X_W*gi +: X_W];
        assign w_y[gi]   = rect_y[Y_W*gi +: Y_W];
        assign w_w[gi]   = rect_w[X_W*gi +: X_W];
        assign w_h[gi]   = rect_h[Y_W*gi +: Y_W];
        assign w_col[gi] = rect_colour[COLOUR_W*gi +: COLOUR_W];
    end

    state_t              r_state, w_next;
    logic [X_W-1:0]      r_x0, r_w, r_cx, r_ox;
    logic [Y_W-1:0]      r_y0, r_h, r_cy, r_oy;
    logic [COLOUR_W-1:0] r_col, r_ocol;
    logic [IDX_W-1:0]    r_last, r_idx;
    logic [NUM_REQ-1:0]  r_grant, r_done;
    logic                r_busy, r_plot;

    logic [NUM_REQ-1:0]  w_winner;
    logic [IDX_W-1:0]    w_idx;
    logic                w_valid;
    logic [X_W:0]        w_px_x;
    logic [Y_W:0]        w_px_y;
    logic                w_row_end, w_last_px, w_zero;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    assign w_px_x    = {1'b0, r_x0} + {1'b0, r_cx};
    assign w_px_y    = {1'b0, r_y0} + {1'b0, r_cy};
    assign w_row_end = (r_cx == r_w - 8'd1);
    assign w_last_px = w_row_end && (r_cy == r_h - 7'd1);
    assign w_zero    = (w_w[w_idx] == '0) || (w_h[w_idx] == '0);

    // A pending done pulse marks the first IDLE cycle, which never grants.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (!(|r_done) && w_valid) w_next = w_zero ? ST_DONE : ST_DRAW;
            ST_DRAW: if (w_last_px) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_col   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_idx   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_ocol  <= '0;
            r_plot  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= '0;
            r_plot  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|r_done) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_valid) begin
                        r_x0    <= w_x[w_idx];
                        r_y0    <= w_y[w_idx];
                        r_w     <= w_w[w_idx];
                        r_h     <= w_h[w_idx];
                        r_col   <= w_col[w_idx];
                        r_idx   <= w_idx;
                        r_grant <= w_winner;
                        r_busy  <= 1'b1;
                        r_cx    <= '0;
                        r_cy    <= '0;
                    end
                end
                ST_DRAW: begin
                    r_ox   <= w_px_x[X_W-1:0];
                    r_oy   <= w_px_y[Y_W-1:0];
                    r_ocol <= r_col;
                    r_plot <= (w_px_x < 9'(SCREEN_W)) && (w_px_y < 8'(SCREEN_H));
                    if (w_row_end) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 7'd1;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_done <= r_grant;
                    r_last <= r_idx;
                end
                default: ;
            endcase
        end
    end

    assign grant   = r_grant;
    assign done    = r_done;
    assign busy    = r_busy;
    assign oX      = r_ox;
    assign oY      = r_oy;
    assign oColour = r_ocol;
    assign oPlot   = r_plot;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_plot_arbiter : directed bench with a transaction model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_vga_plot_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] rect_x = '0;
    logic [7*N-1:0] rect_y = '0;
    logic [8*N-1:0] rect_w = '0;
    logic [7*N-1:0] rect_h = '0;
    logic [9*N-1:0] rect_colour = '0;
    logic [N-1:0]   grant, done;
    logic           busy, oPlot;
    logic [7:0]     oX;
    logic [6:0]     oY;
    logic [8:0]     oColour;

    vga_plot_arbiter #(.NUM_REQ(N), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .reset(reset), .req(req),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_colour(rect_colour),
        .grant(grant), .done(done), .busy(busy),
        .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Transaction-level model: each fill is a timeline of
    // grant cycle, w*h pixel cycles, done cycle, then one idle cycle.
    logic [N-1:0] m_grant, m_done;
    logic         m_busy, m_plot, m_pxv;
    logic [7:0]   m_x;
    logic [6:0]   m_y;
    logic [8:0]   m_col;
    bit           m_act;
    int           m_t, m_win, m_last, mx0, my0, mw, mh, mcol, mp, mix, miy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_grant = '0; m_done = '0; m_busy = 0; m_plot = 0; m_pxv = 1;
            m_x = '0; m_y = '0; m_col = '0; m_act = 0; m_last = N - 1;
        end else begin
            m_done = '0; m_plot = 0; m_pxv = 0;
            if (!m_act) begin
                m_grant = '0; m_busy = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!m_act && req[(m_last + k) % N]) begin
                        m_win = (m_last + k) % N;
                        mx0  = int'(rect_x[8*m_win +: 8]);
                        my0  = int'(rect_y[7*m_win +: 7]);
                        mw   = int'(rect_w[8*m_win +: 8]);
                        mh   = int'(rect_h[7*m_win +: 7]);
                        mcol = int'(rect_colour[9*m_win +: 9]);
                        m_act = 1; m_t = 0; m_busy = 1;
                        m_grant = N'(1) << m_win;
                    end
                end
            end else begin
                m_t++;
                if (m_t <= mw * mh) begin
                    mp  = m_t - 1;
                    mix = mx0 + mp % mw;
                    miy = my0 + mp / mw;
                    m_x = mix[7:0]; m_y = miy[6:0]; m_col = mcol[8:0];
                    m_plot = (mix < 160) && (miy < 120);
                    m_pxv = 1;
                end else if (m_t == mw * mh + 1) begin
                    m_done = m_grant;
                    m_last = m_win;
                end else begin
                    m_act = 0; m_grant = '0; m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("grant", grant, m_grant);
        chk("done", done, m_done);
        chk("busy", busy, m_busy);
        chk("oPlot", oPlot, m_plot);
        if (m_pxv) begin
            chk("oX", oX, m_x);
            chk("oY", oY, m_y);
            chk("oColour", oColour, m_col);
        end
    end

    int           done_q[$];
    int           plot_q[$];
    int           cyc = 0, g_cyc = 0, d_cyc = 0;
    logic [N-1:0] prev_g = '0;

    always @(negedge clk) begin
        cyc++;
        if (oPlot) plot_q.push_back(int'(oX) * 256 + int'(oY));
        for (int i = 0; i < N; i++) if (done[i]) done_q.push_back(i);
        if (|done) d_cyc = cyc;
        if (grant != '0 && prev_g == '0) g_cyc = cyc;
        prev_g = grant;
    end

    bit auto_drop = 1;

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~grant;
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h,
                            input int c);
        rect_x[8*i +: 8]      = x[7:0];
        rect_y[7*i +: 7]      = y[6:0];
        rect_w[8*i +: 8]      = w[7:0];
        rect_h[7*i +: 7]      = h[6:0];
        rect_colour[9*i +: 9] = c[8:0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        done_q.delete();
        plot_q.delete();
    endtask

    task automatic wait_done(input int n, input int max);
        for (int k = 0; k < max && done_q.size() < n; k++) tick();
        if (done_q.size() < n) chk("wait_done timeout", done_q.size(), n);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && busy; k++) tick();
        chk("drain idle", busy, 1'b0);
        tick();
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset grant", grant, 0);
        chk("reset busy", busy, 0);
        chk("reset oPlot", oPlot, 0);
        chk("reset oX", oX, 0);

        // Basic 2x2 fill
        set_rect(0, 10, 20, 2, 2, 9'h1C0);
        req = 3'b001;
        tick(); chk("basic grant e1", grant, 3'b001); chk("basic plot e1", oPlot, 0);
        tick(); chk("basic px0", {oPlot, oX, 1'b0, oY}, {1'b1, 8'd10, 1'b0, 7'd20});
        chk("basic colour", oColour, 9'h1C0);
        tick(); chk("basic px1", {oPlot, oX, 1'b0, oY}, {1'b1, 8'd11, 1'b0, 7'd20});
        tick(); chk("basic px2", {oPlot, oX, 1'b0, oY}, {1'b1, 8'd10, 1'b0, 7'd21});
        tick(); chk("basic px3", {oPlot, oX, 1'b0, oY}, {1'b1, 8'd11, 1'b0, 7'd21});
        tick(); chk("basic done e6", done, 3'b001); chk("basic grant e6", grant, 3'b001);
        chk("basic plot e6", oPlot, 0);
        tick(); chk("basic idle grant", grant, 0); chk("basic idle done", done, 0);
        drain();

        // Simultaneous requests 0 and 2
        do_reset();
        set_rect(0, 1, 1, 1, 1, 9'h007);
        set_rect(2, 5, 6, 1, 1, 9'h038);
        req = 3'b101;
        wait_done(2, 40);
        chk("simul first", done_q[0], 0);
        chk("simul second", done_q[1], 2);
        drain();

        // Fairness with all requests held
        do_reset();
        set_rect(0, 3, 3, 1, 1, 9'h001);
        set_rect(1, 4, 4, 1, 1, 9'h002);
        set_rect(2, 5, 5, 1, 1, 9'h004);
        auto_drop = 0;
        req = 3'b111;
        wait_done(5, 80);
        chk("fair 0", done_q[0], 0);
        chk("fair 1", done_q[1], 1);
        chk("fair 2", done_q[2], 2);
        chk("fair 3", done_q[3], 0);
        chk("fair 4", done_q[4], 1);
        req = '0;
        auto_drop = 1;
        drain();

        // Clipping at the bottom-right corner
        do_reset();
        set_rect(0, 158, 118, 4, 4, 9'h1FF);
        req = 3'b001;
        wait_done(1, 40);
        chk("clip count", plot_q.size(), 4);
        chk("clip p0", plot_q[0], 158 * 256 + 118);
        chk("clip p1", plot_q[1], 159 * 256 + 118);
        chk("clip p2", plot_q[2], 158 * 256 + 119);
        chk("clip p3", plot_q[3], 159 * 256 + 119);
        chk("clip duration", d_cyc - g_cyc, 17);
        drain();

        // Zero-width rectangle
        do_reset();
        set_rect(0, 20, 20, 0, 5, 9'h0F0);
        req = 3'b001;
        wait_done(1, 20);
        chk("zero duration", d_cyc - g_cyc, 1);
        chk("zero plots", plot_q.size(), 0);
        drain();

        // Asynchronous reset in the middle of a 10x10 fill
        do_reset();
        set_rect(0, 0, 0, 10, 10, 9'h0AA);
        req = 3'b001;
        for (int k = 0; k < 80 && plot_q.size() < 37; k++) @(negedge clk);
        chk("midreset reached", plot_q.size(), 37);
        #2;
        reset = 1'b1;
        #1;
        chk("async oPlot", oPlot, 0);
        chk("async busy", busy, 0);
        chk("async grant", grant, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_q.delete();
        set_rect(0, 30, 30, 1, 1, 9'h111);
        set_rect(1, 40, 40, 1, 1, 9'h122);
        req = 3'b011;
        wait_done(2, 40);
        chk("post reset first", done_q[0], 0);
        chk("post reset second", done_q[1], 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
